// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and types for the multiplier result path.
package mult_pkg;
  localparam int PROD_W = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;
  typedef logic signed [PROD_W-1:0] product_t;
endpackage

// File: rtl/mult_accum_collector_if.sv
// mult_accum_collector_if: one-entry valid/ready result bus {product, running sum, count}.
interface mult_accum_collector_if
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic res_valid;
  logic res_ready;
  product_t res_product;
  logic signed [ACC_W-1:0] res_sum;
  logic [CNT_W-1:0] res_count;
  modport master(output res_valid, res_product, res_sum, res_count, input res_ready);
  modport slave(input res_valid, res_product, res_sum, res_count, output res_ready);
endinterface

// File: rtl/mult_accum_collector_sat_add.sv
// sat_add: signed accumulator + product adder with overflow flag.
// MULT_ACCUM_SAT_EN defined clamps the sum to the signed range; otherwise it wraps.
module sat_add
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  input  product_t                addend,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);
  logic [ACC_W:0] full;
  // One guard bit: overflow whenever it disagrees with the sign bit.
  assign full = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){addend[PROD_W-1]}}, addend};
  assign ovf = full[ACC_W] ^ full[ACC_W-1];
`ifdef MULT_ACCUM_SAT_EN
  assign sum = ovf ? {full[ACC_W], {(ACC_W-1){~full[ACC_W]}}} : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/mult_accum_collector.sv
// mult_accum_collector: captures each multiplier completion, accumulates it and buffers the result.
// Saturating accumulation is selected with MULT_ACCUM_SAT_EN.
module mult_accum_collector
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         done,
  input  product_t                     product,
  mult_accum_collector_if.master       res_if,
  output logic                         overflow,
  output logic                         dropped
);
  logic done_q, cap, free, accept, ovf;
  logic signed [ACC_W-1:0] acc, sum;
  logic [CNT_W-1:0] count;
  assign cap = done & ~done_q;
  assign free = ~res_if.res_valid | res_if.res_ready;
  assign accept = cap & free & ~clear;
  sat_add #(.ACC_W(ACC_W)) u_add (.acc(acc), .addend(product), .sum(sum), .ovf(ovf));
  // done_q resets high so a done already asserted at release is not seen as a new edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b1;
      acc <= '0;
      count <= '0;
      overflow <= 1'b0;
      dropped <= 1'b0;
      res_if.res_valid <= 1'b0;
      res_if.res_product <= '0;
      res_if.res_sum <= '0;
      res_if.res_count <= '0;
    end else begin
      done_q <= done;
      if (clear) begin
        acc <= '0;
        count <= '0;
        overflow <= 1'b0;
        dropped <= 1'b0;
        res_if.res_valid <= 1'b0;
      end else if (accept) begin
        acc <= sum;
        count <= count + 1'b1;
        overflow <= overflow | ovf;
        res_if.res_valid <= 1'b1;
        res_if.res_product <= product;
        res_if.res_sum <= sum;
        res_if.res_count <= count + 1'b1;
      end else begin
        if (res_if.res_valid & res_if.res_ready) res_if.res_valid <= 1'b0;
        if (cap) dropped <= 1'b1;
      end
    end
  end
endmodule
